// File: rtl/alu_issue_ctrl_if.sv
// Issue handshake and register-file port bundle for alu_issue_ctrl.
// master = controller side, slave = upstream issue logic plus register file.
interface alu_issue_ctrl_if;
    logic        inst_valid;
    logic [31:0] inst;
    logic        inst_ready;
    logic [4:0]  R_Addr_A;
    logic [4:0]  R_Addr_B;
    logic [31:0] R_Data_A;
    logic [31:0] R_Data_B;
    logic        Reg_Write;
    logic [4:0]  W_Addr;
    logic [31:0] W_Data;
    logic        done;
    logic        illegal;

    modport master (
        input  inst_valid, inst, R_Data_A, R_Data_B,
        output inst_ready, R_Addr_A, R_Addr_B, Reg_Write, W_Addr, W_Data, done, illegal
    );

    modport slave (
        output inst_valid, inst, R_Data_A, R_Data_B,
        input  inst_ready, R_Addr_A, R_Addr_B, Reg_Write, W_Addr, W_Data, done, illegal
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue/execute controller for RV32I register and immediate ALU ops:
// IDLE -> DECODE (read operands) -> EXEC (compute) -> WB (single-cycle write-back).
module alu_issue_ctrl (
    input  logic           clk,
    input  logic           rst_n,
    alu_issue_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        EXEC,
        WB
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD,
        OP_SUB,
        OP_SLL,
        OP_SLT,
        OP_SLTU,
        OP_XOR,
        OP_SRL,
        OP_SRA,
        OP_OR,
        OP_AND
    } alu_op_t;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    state_t      state_q, state_d;
    logic [31:0] inst_q;
    logic [31:0] op_a_q, op_b_q, result_q;
    alu_op_t     op_q, op_d;
    logic        reg_write_q, done_q, illegal_q;
    logic        reg_write_d, illegal_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        is_r, is_i, f7_base, f7_alt;
    logic        legal_d;
    logic [31:0] op_b_d;
    logic [31:0] result_d;
    logic [4:0]  shamt;
    logic        accept;

    assign accept = (state_q == IDLE) && bus.inst_valid;

    // Instruction decode of the held word; only consumed while in DECODE.
    always_comb begin
        opcode  = inst_q[6:0];
        funct3  = inst_q[14:12];
        funct7  = inst_q[31:25];
        imm     = {{20{inst_q[31]}}, inst_q[31:20]};
        is_r    = (opcode == OPC_OP);
        is_i    = (opcode == OPC_OPIMM);
        f7_base = (funct7 == F7_BASE);
        f7_alt  = (funct7 == F7_ALT);

        op_d    = OP_ADD;
        op_b_d  = is_r ? bus.R_Data_B : imm;
        legal_d = 1'b0;

        case (funct3)
            3'b000:  op_d = (is_r && f7_alt) ? OP_SUB : OP_ADD;
            3'b001:  op_d = OP_SLL;
            3'b010:  op_d = OP_SLT;
            3'b011:  op_d = OP_SLTU;
            3'b100:  op_d = OP_XOR;
            3'b101:  op_d = f7_alt ? OP_SRA : OP_SRL;
            3'b110:  op_d = OP_OR;
            default: op_d = OP_AND;
        endcase

        // Immediate ops only constrain funct7 for the shifts, where it is part of imm.
        if (is_r) begin
            legal_d = f7_base || (f7_alt && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        end else if (is_i) begin
            if (funct3 == 3'b001) begin
                legal_d = f7_base;
            end else if (funct3 == 3'b101) begin
                legal_d = f7_base || f7_alt;
            end else begin
                legal_d = 1'b1;
            end
        end
    end

    always_comb begin
        shamt    = op_b_q[4:0];
        result_d = '0;
        case (op_q)
            OP_ADD:  result_d = op_a_q + op_b_q;
            OP_SUB:  result_d = op_a_q - op_b_q;
            OP_SLL:  result_d = op_a_q << shamt;
            OP_SLT:  result_d = {31'd0, ($signed(op_a_q) < $signed(op_b_q))};
            OP_SLTU: result_d = {31'd0, (op_a_q < op_b_q)};
            OP_XOR:  result_d = op_a_q ^ op_b_q;
            OP_SRL:  result_d = op_a_q >> shamt;
            OP_SRA:  result_d = $unsigned($signed(op_a_q) >>> shamt);
            OP_OR:   result_d = op_a_q | op_b_q;
            OP_AND:  result_d = op_a_q & op_b_q;
            default: result_d = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        reg_write_d = 1'b0;
        illegal_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.inst_valid) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (legal_d) begin
                    state_d = EXEC;
                end else begin
                    state_d   = IDLE;
                    illegal_d = 1'b1;
                end
            end
            EXEC: begin
                state_d     = WB;
                reg_write_d = 1'b1;
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            reg_write_q <= 1'b0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            reg_write_q <= reg_write_d;
            done_q      <= reg_write_d;
            illegal_q   <= illegal_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q   <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_q     <= OP_ADD;
            result_q <= '0;
        end else begin
            if (accept) begin
                inst_q <= bus.inst;
            end
            if (state_q == DECODE) begin
                op_a_q <= bus.R_Data_A;
                op_b_q <= op_b_d;
                op_q   <= op_d;
            end
            if (state_q == EXEC) begin
                result_q <= result_d;
            end
        end
    end

    assign bus.inst_ready = (state_q == IDLE);
    assign bus.R_Addr_A   = inst_q[19:15];
    assign bus.R_Addr_B   = inst_q[24:20];
    assign bus.Reg_Write  = reg_write_q;
    assign bus.done       = done_q;
    assign bus.illegal    = illegal_q;
    assign bus.W_Addr     = inst_q[11:7];
    assign bus.W_Data     = result_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: register file plus an accept-timeline model checked every cycle,
// and directed instructions with hand-computed write-back values.
module tb_alu_issue_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned wr_count = 0;

    logic [31:0] rf [32];
    logic [31:0] gm [32];
    logic        pl_en;
    logic [4:0]  pl_addr;
    logic [31:0] pl_data;

    assign bus.R_Data_A = rf[bus.R_Addr_A];
    assign bus.R_Data_B = rf[bus.R_Addr_B];

    // Environment register file: commits on the edge that ends the write-back cycle.
    always @(posedge clk) begin
        if (pl_en) begin
            rf[pl_addr] <= pl_data;
        end else if (bus.Reg_Write && bus.W_Addr != 5'd0) begin
            rf[bus.W_Addr] <= bus.W_Data;
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus.Reg_Write) wr_count++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {im, rs1, f3, rd, 7'b0010011};
    endfunction

    // Architectural meaning of one instruction: {legal, rd value}.
    function automatic logic [32:0] model_exec(input logic [31:0] w, input logic [31:0] a,
                                               input logic [31:0] rb);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] b;
        logic [31:0] r;
        logic        ok;
        opc = w[6:0];
        f3  = w[14:12];
        f7  = w[31:25];
        b   = (opc == 7'h33) ? rb : {{20{w[31]}}, w[31:20]};
        r   = 32'd0;
        ok  = 1'b0;
        if (opc == 7'h33 || opc == 7'h13) begin
            case (f3)
                3'd0: r = (opc == 7'h33 && f7 == 7'h20) ? a - b : a + b;
                3'd1: r = a << b[4:0];
                3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: r = (a < b) ? 32'd1 : 32'd0;
                3'd4: r = a ^ b;
                3'd5: r = (f7 == 7'h20) ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
                3'd6: r = a | b;
                default: r = a & b;
            endcase
            if (opc == 7'h33) ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            else if (f3 == 3'd1) ok = (f7 == 7'h00);
            else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
            else ok = 1'b1;
        end
        return {ok, r};
    endfunction

    // Model: age = cycles since the accepting edge.
    logic        m_busy, m_legal, m_rdy;
    int unsigned m_age;
    logic [31:0] m_inst, m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_legal = 1'b0;
            m_age   = 0;
        end else begin
            m_rdy = !m_busy || (!m_legal && m_age == 1);
            if (pl_en) gm[pl_addr] = pl_data;
            if (m_busy) begin
                m_age++;
                if (m_legal && m_age == 3) begin
                    if (m_inst[11:7] != 5'd0) gm[m_inst[11:7]] = m_res;
                    m_busy = 1'b0;
                end else if (!m_legal && m_age == 2) begin
                    m_busy = 1'b0;
                end
            end
            if (m_rdy && bus.inst_valid) begin
                {m_legal, m_res} = model_exec(bus.inst, gm[bus.inst[19:15]], gm[bus.inst[24:20]]);
                m_inst = bus.inst;
                m_busy = 1'b1;
                m_age  = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic exp_rdy, exp_wr, exp_ill;
        if (rst_n) begin
            exp_rdy = !m_busy || (!m_legal && m_age == 1);
            exp_wr  = m_busy && m_legal && m_age == 2;
            exp_ill = m_busy && !m_legal && m_age == 1;
            chk("m_inst_ready", 32'(bus.inst_ready), 32'(exp_rdy));
            chk("m_Reg_Write", 32'(bus.Reg_Write), 32'(exp_wr));
            chk("m_done", 32'(bus.done), 32'(exp_wr));
            chk("m_illegal", 32'(bus.illegal), 32'(exp_ill));
            if (exp_wr) begin
                chk("m_W_Addr", 32'(bus.W_Addr), 32'(m_inst[11:7]));
                chk("m_W_Data", bus.W_Data, m_res);
            end
            if (m_busy && m_age == 0) begin
                chk("m_R_Addr_A", 32'(bus.R_Addr_A), 32'(m_inst[19:15]));
                chk("m_R_Addr_B", 32'(bus.R_Addr_B), 32'(m_inst[24:20]));
            end
        end
    end

    function automatic logic [31:0] init_val(input int unsigned i);
        case (i)
            0:  return 32'h0000_0000;
            1:  return 32'h0000_0005;
            2:  return 32'h0000_0007;
            7:  return 32'h8000_0000;
            8:  return 32'h0000_0001;
            9:  return 32'hFFFF_FFFF;
            10: return 32'h0000_0001;
            11: return 32'hFFFF_FFFE;
            default: return 32'h1000_0000 + 32'(i) * 32'h0000_3579;
        endcase
    endfunction

    task automatic preload(input int unsigned i);
        pl_en   = 1'b1;
        pl_addr = 5'(i);
        pl_data = init_val(i);
        @(posedge clk); #1;
        pl_en   = 1'b0;
    endtask

    // Returns 1ns after the accepting edge (DECODE cycle).
    task automatic issue(input logic [31:0] w);
        int unsigned n;
        n = 0;
        @(posedge clk); #1;
        while (!bus.inst_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            n_checks++;
            $display("FAIL issue_wait: inst_ready stayed 0, expected 1 within 20 cycles");
        end
        bus.inst_valid = 1'b1;
        bus.inst       = w;
        @(posedge clk); #1;
        bus.inst_valid = 1'b0;
    endtask

    task automatic run_wb(input string name, input logic [31:0] w, input logic [4:0] rd,
                          input logic [31:0] exp);
        issue(w);
        repeat (2) begin @(posedge clk); #1; end
        chk({name, "_Reg_Write"}, 32'(bus.Reg_Write), 32'd1);
        chk({name, "_done"}, 32'(bus.done), 32'd1);
        chk({name, "_W_Addr"}, 32'(bus.W_Addr), 32'(rd));
        chk({name, "_W_Data"}, bus.W_Data, exp);
        @(posedge clk); #1;
        chk({name, "_Reg_Write_end"}, 32'(bus.Reg_Write), 32'd0);
        chk({name, "_ready_end"}, 32'(bus.inst_ready), 32'd1);
    endtask

    task automatic run_illegal(input string name, input logic [31:0] w);
        int unsigned wr0;
        wr0 = wr_count;
        issue(w);
        @(posedge clk); #1;
        chk({name, "_illegal"}, 32'(bus.illegal), 32'd1);
        chk({name, "_ready"}, 32'(bus.inst_ready), 32'd1);
        chk({name, "_Reg_Write"}, 32'(bus.Reg_Write), 32'd0);
        repeat (3) begin @(posedge clk); #1; end
        chk({name, "_illegal_end"}, 32'(bus.illegal), 32'd0);
        chk({name, "_no_write"}, wr_count, wr0);
    endtask

    logic [31:0] extra [15];

    initial begin
        int unsigned wr0;
        rst_n          = 1'b0;
        bus.inst_valid = 1'b0;
        bus.inst       = 32'd0;
        pl_en          = 1'b0;
        pl_addr        = 5'd0;
        pl_data        = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_inst_ready", 32'(bus.inst_ready), 32'd1);
        chk("rst_Reg_Write", 32'(bus.Reg_Write), 32'd0);
        chk("rst_W_Addr", 32'(bus.W_Addr), 32'd0);
        chk("rst_W_Data", bus.W_Data, 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_illegal", 32'(bus.illegal), 32'd0);
        chk("rst_R_Addr_A", 32'(bus.R_Addr_A), 32'd0);
        chk("rst_R_Addr_B", 32'(bus.R_Addr_B), 32'd0);
        rst_n = 1'b1;

        for (int unsigned i = 0; i < 32; i++) preload(i);

        run_wb("addi_neg", 32'hFFD0_0293, 5'd5, 32'hFFFF_FFFD);

        issue(32'h4020_81B3);
        chk("sub_R_Addr_A", 32'(bus.R_Addr_A), 32'd1);
        chk("sub_R_Addr_B", 32'(bus.R_Addr_B), 32'd2);
        repeat (2) begin @(posedge clk); #1; end
        chk("sub_W_Addr", 32'(bus.W_Addr), 32'd3);
        chk("sub_W_Data", bus.W_Data, 32'hFFFF_FFFE);

        run_wb("srai", enc_i(12'h404, 5'd7, 3'd5, 5'd12), 5'd12, 32'hF800_0000);
        run_wb("srli", enc_i(12'h004, 5'd7, 3'd5, 5'd13), 5'd13, 32'h0800_0000);
        run_wb("slli", enc_i(12'h004, 5'd8, 3'd1, 5'd14), 5'd14, 32'h0000_0010);
        run_wb("slt", enc_r(7'h00, 5'd10, 5'd9, 3'd2, 5'd15), 5'd15, 32'd1);
        run_wb("sltu", enc_r(7'h00, 5'd10, 5'd9, 3'd3, 5'd16), 5'd16, 32'd0);
        run_wb("sltiu", enc_i(12'hFFF, 5'd11, 3'd3, 5'd17), 5'd17, 32'd1);

        run_illegal("ill_system", 32'h0000_0073);
        run_illegal("ill_add_f7", enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd3));

        extra[0]  = enc_r(7'h00, 5'd8, 5'd7, 3'd4, 5'd19);
        extra[1]  = enc_r(7'h00, 5'd10, 5'd9, 3'd6, 5'd20);
        extra[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd21);
        extra[3]  = enc_r(7'h00, 5'd8, 5'd7, 3'd5, 5'd22);
        extra[4]  = enc_r(7'h20, 5'd8, 5'd7, 3'd5, 5'd23);
        extra[5]  = enc_r(7'h00, 5'd8, 5'd1, 3'd1, 5'd24);
        extra[6]  = enc_i(12'h7FF, 5'd1, 3'd0, 5'd25);
        extra[7]  = enc_i(12'hFFF, 5'd8, 3'd2, 5'd26);
        extra[8]  = enc_i(12'h0F0, 5'd9, 3'd4, 5'd27);
        extra[9]  = enc_i(12'h800, 5'd3, 3'd6, 5'd28);
        extra[10] = enc_i(12'h00F, 5'd9, 3'd7, 5'd29);
        extra[11] = enc_r(7'h20, 5'd2, 5'd1, 3'd1, 5'd30);
        extra[12] = enc_i(12'h404, 5'd7, 3'd1, 5'd31);
        extra[13] = 32'h0000_0003;
        extra[14] = enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd0);
        for (int unsigned i = 0; i < 15; i++) begin
            issue(extra[i]);
            repeat (3) @(posedge clk);
            #1;
        end

        // Reset while the ADD sits in EXEC: the write-back must never appear.
        wr0 = wr_count;
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd18));
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_inst_ready", 32'(bus.inst_ready), 32'd1);
        chk("midrst_Reg_Write", 32'(bus.Reg_Write), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_W_Addr", 32'(bus.W_Addr), 32'd0);
        chk("midrst_W_Data", bus.W_Data, 32'd0);
        chk("midrst_R_Addr_A", 32'(bus.R_Addr_A), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        chk("midrst_no_write", wr_count, wr0);

        issue(enc_i(12'd9, 5'd0, 3'd0, 5'd1));
        issue(enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2));
        repeat (2) begin @(posedge clk); #1; end
        chk("raw_Reg_Write", 32'(bus.Reg_Write), 32'd1);
        chk("raw_W_Addr", 32'(bus.W_Addr), 32'd2);
        chk("raw_W_Data", bus.W_Data, 32'd18);
        repeat (3) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
